// File: rtl/phy_130b_pkg.sv
// Shared 130b PHY definitions: block width, sync header codes, alignment states.
package phy_130b_pkg;

    localparam int BLK_W = 130;
    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    // How many bits the gearbox drops from the head of its buffer this cycle.
    typedef enum logic [1:0] {
        CONS_NONE = 2'd0,
        CONS_130  = 2'd1,
        CONS_131  = 2'd2
    } consume_t;

    function automatic logic sync_ok(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/block_aligner_130b_if.sv
// Aligner bus: raw word stream in, aligned 130-bit blocks and status out.
// Stats ports exist only when ALIGN_STATS_EN is defined.
interface block_aligner_130b_if #(
    parameter int IN_W = 32
);
    import phy_130b_pkg::*;

    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic [BLK_W-1:0] block_out;
    logic             valid_out;
    logic             locked;
    logic             slip_pulse;
`ifdef ALIGN_STATS_EN
    logic [15:0]      err_cnt;
    logic [7:0]       lock_loss_cnt;

    modport master (output in_data, in_valid,
                    input  block_out, valid_out, locked, slip_pulse, err_cnt, lock_loss_cnt);
    modport slave  (input  in_data, in_valid,
                    output block_out, valid_out, locked, slip_pulse, err_cnt, lock_loss_cnt);
`else
    modport master (output in_data, in_valid,
                    input  block_out, valid_out, locked, slip_pulse);
    modport slave  (input  in_data, in_valid,
                    output block_out, valid_out, locked, slip_pulse);
`endif

endinterface

// File: rtl/block_aligner_130b_gearbox.sv
// Bit buffer for the aligner: appends IN_W-bit words, presents the oldest 130 bits
// and the post-append fill, and drops 130 or 131 bits on request.
module gearbox_130b
    import phy_130b_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int FILL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    input  consume_t          consume,
    output logic [BLK_W-1:0]  cand,
    output logic [FILL_W-1:0] fill_app
);
    localparam int BUF_W = BLK_W + 1 + IN_W;

    // Oldest bit lives at [BUF_W-1]; everything below fill is kept zero so OR-append works.
    logic [BUF_W-1:0]  bits_q;
    logic [BUF_W-1:0]  bits_app;
    logic [BUF_W-1:0]  ext;
    logic [FILL_W-1:0] fill_q;

    always_comb begin
        ext      = {in_data, {(BUF_W-IN_W){1'b0}}};
        bits_app = bits_q;
        fill_app = fill_q;
        if (in_valid) begin
            bits_app = bits_q | (ext >> fill_q);
            fill_app = fill_q + FILL_W'(IN_W);
        end
    end

    assign cand = bits_app[BUF_W-1 -: BLK_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q <= '0;
            fill_q <= '0;
        end else begin
            case (consume)
                CONS_130: begin
                    bits_q <= bits_app << BLK_W;
                    fill_q <= fill_app - FILL_W'(BLK_W);
                end
                CONS_131: begin
                    bits_q <= bits_app << (BLK_W + 1);
                    fill_q <= fill_app - FILL_W'(BLK_W + 1);
                end
                default: begin
                    bits_q <= bits_app;
                    fill_q <= fill_app;
                end
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst_n) assert (fill_app <= FILL_W'(BUF_W));
    end

endmodule

// File: rtl/block_aligner_130b.sv
// 130b block aligner: gearbox plus hunt/verify/lock FSM driven by sync headers.
// Optional ALIGN_STATS_EN adds saturating err_cnt and lock_loss_cnt outputs.
module block_aligner_130b
    import phy_130b_pkg::*;
#(
    parameter int IN_W     = 32,
    parameter int LOCK_CNT = 4,
    parameter int WINDOW   = 64,
    parameter int BAD_MAX  = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    block_aligner_130b_if.slave bus
);
    localparam int BUF_W  = BLK_W + 1 + IN_W;
    localparam int FILL_W = $clog2(BUF_W + IN_W + 1);
    localparam int GW     = $clog2(LOCK_CNT + 1);
    localparam int WW     = $clog2(WINDOW + 1);
    localparam int BW     = $clog2(BAD_MAX + 1);

    align_state_t      state;
    consume_t          cons;
    logic [BLK_W-1:0]  cand;
    logic [FILL_W-1:0] fill_app;
    logic              hdr_good, ge130, ge131;
    logic              bad_in_lock, lose_lock;
    logic [GW-1:0]     good_cnt;
    logic [WW-1:0]     blk_cnt;
    logic [BW-1:0]     bad_cnt;
    logic [BLK_W-1:0]  blk_q;
    logic              vld_q, lck_q, slip_q;

    gearbox_130b #(.IN_W(IN_W), .FILL_W(FILL_W)) u_gearbox (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (bus.in_data),
        .in_valid (bus.in_valid),
        .consume  (cons),
        .cand     (cand),
        .fill_app (fill_app)
    );

    assign hdr_good = sync_ok(cand[BLK_W-1 -: 2]);
    assign ge130    = fill_app >= FILL_W'(BLK_W);
    assign ge131    = fill_app >= FILL_W'(BLK_W + 1);

    // A bad header in VERIFY needs 131 bits for its slip, so it waits for them.
    always_comb begin
        cons = CONS_NONE;
        case (state)
            HUNT:    if (ge131) cons = hdr_good ? CONS_130 : CONS_131;
            VERIFY:  if (hdr_good ? ge130 : ge131) cons = hdr_good ? CONS_130 : CONS_131;
            LOCKED:  if (ge130) cons = CONS_130;
            default: cons = CONS_NONE;
        endcase
    end

    assign bad_in_lock = (state == LOCKED) && (cons != CONS_NONE) && !hdr_good;
    assign lose_lock   = bad_in_lock && ((bad_cnt + BW'(1)) == BW'(BAD_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            good_cnt <= '0;
            blk_cnt  <= '0;
            bad_cnt  <= '0;
            blk_q    <= '0;
            vld_q    <= 1'b0;
            lck_q    <= 1'b0;
            slip_q   <= 1'b0;
        end else begin
            vld_q  <= 1'b0;
            slip_q <= 1'b0;
            if (cons != CONS_NONE) begin
                case (state)
                    HUNT: begin
                        if (!hdr_good) begin
                            slip_q <= 1'b1;
                        end else if (LOCK_CNT <= 1) begin
                            state   <= LOCKED;
                            lck_q   <= 1'b1;
                            vld_q   <= 1'b1;
                            blk_q   <= cand;
                            blk_cnt <= '0;
                            bad_cnt <= '0;
                        end else begin
                            state    <= VERIFY;
                            good_cnt <= GW'(1);
                        end
                    end
                    VERIFY: begin
                        if (!hdr_good) begin
                            slip_q   <= 1'b1;
                            state    <= HUNT;
                            good_cnt <= '0;
                        end else if ((good_cnt + GW'(1)) == GW'(LOCK_CNT)) begin
                            state    <= LOCKED;
                            lck_q    <= 1'b1;
                            vld_q    <= 1'b1;
                            blk_q    <= cand;
                            good_cnt <= '0;
                            blk_cnt  <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            good_cnt <= good_cnt + GW'(1);
                        end
                    end
                    LOCKED: begin
                        vld_q <= 1'b1;
                        blk_q <= cand;
                        if (lose_lock) begin
                            state <= HUNT;
                            lck_q <= 1'b0;
                        end else if (blk_cnt == WW'(WINDOW - 1)) begin
                            blk_cnt <= '0;
                            bad_cnt <= '0;
                        end else begin
                            blk_cnt <= blk_cnt + WW'(1);
                            bad_cnt <= bad_cnt + BW'(bad_in_lock);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign bus.block_out  = blk_q;
    assign bus.valid_out  = vld_q;
    assign bus.locked     = lck_q;
    assign bus.slip_pulse = slip_q;

`ifdef ALIGN_STATS_EN
    logic [15:0] err_q;
    logic [7:0]  loss_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= '0;
            loss_q <= '0;
        end else begin
            if (bad_in_lock && (err_q != 16'hFFFF)) err_q  <= err_q + 16'd1;
            if (lose_lock && (loss_q != 8'hFF))     loss_q <= loss_q + 8'd1;
        end
    end

    assign bus.err_cnt       = err_q;
    assign bus.lock_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_block_aligner_130b.sv
// Scoreboard bench for block_aligner_130b: builds bit streams, predicts emitted blocks.
module tb_block_aligner_130b;
    import phy_130b_pkg::*;

    localparam int IN_W     = 32;
    localparam int LOCK_CNT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    block_aligner_130b_if #(.IN_W(IN_W)) bus ();

    block_aligner_130b #(.IN_W(IN_W), .LOCK_CNT(LOCK_CNT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [BLK_W-1:0] blk;
        logic             lck;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   stream_q[$];
    bit   sb[$];
    bit   hm[$];
    int   starts[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   slip_cnt = 0;

    task automatic chk(input string tag, input logic [BLK_W-1:0] got, input logic [BLK_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.slip_pulse) slip_cnt++;
            if (bus.valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("block", bus.block_out, mon_e.blk);
                    chk("locked_with_valid", BLK_W'(bus.locked), BLK_W'(mon_e.lck));
                end
            end
        end
    end

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) == 1) ? SYNC_DATA : SYNC_CTRL;
    endfunction

    task automatic add_bits(input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back(1'($urandom_range(0, 1)));
            hm.push_back(1'b0);
        end
    endtask

    task automatic add_block(input logic [1:0] hdr);
        starts.push_back(sb.size());
        sb.push_back(hdr[1]); hm.push_back(1'b1);
        sb.push_back(hdr[0]); hm.push_back(1'b1);
        add_bits(128);
    endtask

    // Walk the hunt positions (131-bit steps) and force each off-frame candidate header
    // to 00/11 without touching real headers; returns where the first real header is met.
    task automatic fix_hunt(input int h, output int p_lock);
        int  p;
        bit  done;
        p      = h;
        p_lock = -1;
        done   = 1'b0;
        for (int it = 0; it < 200 && !done; it++) begin
            if (p + 1 >= sb.size()) begin
                done = 1'b1;
            end else if (hm[p] && hm[p+1]) begin
                p_lock = p;
                done   = 1'b1;
            end else begin
                if (!hm[p+1]) sb[p+1] = sb[p];
                else          sb[p]   = sb[p+1];
                p += BLK_W + 1;
            end
        end
    endtask

    task automatic commit(input int h, input bit last_unlock);
        int   p_lock;
        int   thr;
        exp_t e;
        fix_hunt(h, p_lock);
        thr = (p_lock < 0) ? sb.size() : p_lock + (LOCK_CNT - 1) * BLK_W;
        foreach (starts[i]) begin
            if (starts[i] >= thr) begin
                for (int b = 0; b < BLK_W; b++) e.blk[BLK_W-1-b] = sb[starts[i] + b];
                e.lck = !(last_unlock && (i == starts.size() - 1));
                exp_q.push_back(e);
            end
        end
        foreach (sb[i]) stream_q.push_back(sb[i]);
        sb.delete();
        hm.delete();
        starts.delete();
    endtask

    task automatic drive_word();
        logic [IN_W-1:0] w;
        @(posedge clk); #1;
        if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        for (int i = 0; i < IN_W; i++) w[IN_W-1-i] = stream_q.pop_front();
        bus.in_data  = w;
        bus.in_valid = 1'b1;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drive_all();
        while (stream_q.size() >= IN_W) drive_word();
        idle();
    endtask

    task automatic drive_words(input int n);
        for (int i = 0; i < n && stream_q.size() >= IN_W; i++) drive_word();
        idle();
    endtask

    task automatic pad_flush();
        while ((stream_q.size() % IN_W) != 0) stream_q.push_back(1'b0);
        drive_all();
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk(tag, BLK_W'(exp_q.size()), 0);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        stream_q.delete();
        repeat (2) @(posedge clk);
        slip_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_block_out"}, bus.block_out, 0);
        chk({tag, "_valid_out"}, BLK_W'(bus.valid_out), 0);
        chk({tag, "_locked"}, BLK_W'(bus.locked), 0);
        chk({tag, "_slip"}, BLK_W'(bus.slip_pulse), 0);
`ifdef ALIGN_STATS_EN
        chk({tag, "_err_cnt"}, BLK_W'(bus.err_cnt), 0);
        chk({tag, "_lock_loss"}, BLK_W'(bus.lock_loss_cnt), 0);
`endif
    endtask

    initial begin
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Aligned stream: lock on block 3, then windows with 7 bad, 7 bad, then 8 bad.
        for (int i = 0; i < LOCK_CNT; i++) add_block(SYNC_DATA);
        for (int w = 0; w < 3; w++) begin
            for (int j = 0; j < 64; j++) begin
                if ((w == 0 && j < 7) || (w == 1 && j >= 10 && j < 17) || (w == 2 && j < 8))
                    add_block((j % 2 == 1) ? 2'b11 : 2'b00);
                else if (w == 2 && j >= 8)
                    break;
                else
                    add_block(SYNC_DATA);
            end
        end
        commit(0, 1'b1);
        drive_all();
        pad_flush();
        wait_drain("aligned_drain");
        chk("aligned_slips", BLK_W'(slip_cnt), 0);
        chk("locked_after_8_bad", BLK_W'(bus.locked), 0);
`ifdef ALIGN_STATS_EN
        chk("err_cnt", BLK_W'(bus.err_cnt), 22);
        chk("lock_loss_cnt", BLK_W'(bus.lock_loss_cnt), 1);
`endif

        // Three good headers, a bad one in VERIFY, then a new frame 20 bits later.
        do_reset();
        for (int i = 0; i < 3; i++) add_block(SYNC_DATA);
        add_block(2'b11);
        add_bits(20);
        for (int i = 0; i < 26; i++) add_block(good_hdr());
        commit(4 * BLK_W + 1, 1'b0);
        drive_all();
        pad_flush();
        wait_drain("verify_abort_drain");
        chk("verify_abort_slips", BLK_W'(slip_cnt), 20);
        chk("verify_abort_relock", BLK_W'(bus.locked), 1);

        // 57-bit offset: acquire, then reset in the middle of a locked block.
        do_reset();
        add_bits(57);
        for (int i = 0; i < 66; i++) add_block(good_hdr());
        commit(0, 1'b0);
        drive_words(267);
        repeat (3) @(posedge clk);
        #1;
        chk("offset57_slips", BLK_W'(slip_cnt), 57);
        chk("offset57_locked", BLK_W'(bus.locked), 1);
        chk("offset57_pending", BLK_W'(exp_q.size()), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midblock_reset");
        exp_q.delete();
        stream_q.delete();
        slip_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        add_bits(57);
        for (int i = 0; i < 64; i++) add_block(good_hdr());
        commit(0, 1'b0);
        drive_all();
        pad_flush();
        wait_drain("reacquire_drain");
        chk("reacquire_slips", BLK_W'(slip_cnt), 57);
        chk("reacquire_locked", BLK_W'(bus.locked), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/block_aligner_130b.md
Name: block_aligner_130b

Overview:
- Upstream neighbour of the 128b/130b decoder. Takes the deserialized receive bit stream as IN_W-bit words and assembles it into 130-bit blocks (a gearbox).
- Finds and holds block alignment from the sync headers using a hunt / verify / lock state machine.
- Emits aligned 130-bit blocks with a valid strobe, in the decoder's input format: sync header in bits [129:128], payload in bits [127:0].

Parameters:
- IN_W, 32, input word width; legal values 8, 16, 32, 64.
- LOCK_CNT, 4, consecutive good sync headers needed to declare lock.
- WINDOW, 64, block window for loss-of-lock evaluation.
- BAD_MAX, 8, bad headers within one WINDOW that force loss of lock.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- in_data  input  IN_W  received bits; in_data[IN_W-1] is the earliest bit in time
- in_valid  input  1  in_data valid this cycle
- block_out  output  130  aligned block; first received bit at [129]
- valid_out  output  1  block_out valid (one-cycle strobe)
- locked  output  1  alignment locked
- slip_pulse  output  1  one-cycle strobe when a 1-bit slip is performed

Behaviour:
- Single clock. Reset is asynchronous, active-low. The reset value of every output is 0.
- Reset clears the buffer, the fill count, the state (to HUNT) and all counters. Reset asserted mid-block discards any partial data.
- Bit buffer, 131+IN_W bits:
  - On in_valid, in_data is appended behind the existing bits and fill += IN_W.
  - Append and consume may occur in the same cycle. The consume decision is based on the post-append fill.
  - At most one block is evaluated per cycle. The buffer can never overflow; assert this in simulation.
- A candidate block is the oldest 130 buffered bits. A header is good if cand[129:128] is 01 or 10, and bad if it is 00 or 11.
- States (2-bit encoding):
  - HUNT:
    - Evaluate only when post-append fill >= 131.
    - Good header: consume 130 bits, set good_cnt=1, go to VERIFY.
    - Bad header: consume 131 bits (a 1-bit slip) and pulse slip_pulse.
    - No output.
  - VERIFY:
    - Evaluate when fill >= 130 (130 bits consumed) and when fill >= 131 (131 bits consumed).
    - Good header: good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCKED and emit that block.
    - Bad header: consume 131 bits, pulse slip_pulse, return to HUNT.
    - No output before lock.
  - LOCKED:
    - Evaluate when fill >= 130.
    - Every block is emitted, bad-header blocks included; the decoder flags those.
    - blk_cnt counts 0..WINDOW-1. bad_cnt counts bad headers within the window.
    - When bad_cnt reaches BAD_MAX, go to HUNT, drop locked, and emit no slip. The offending block is still emitted.
    - When blk_cnt wraps, clear bad_cnt.
- Output timing:
  - block_out and valid_out are registered: 1-cycle latency from the evaluating cycle.
  - locked is registered and rises in the same cycle as the first valid_out.
  - block_out holds its last value while valid_out=0.
- in_valid=0 with fill below threshold: nothing happens and the state holds.
- Worst-case acquisition: 130 slips × ceil(131/IN_W) cycles, plus verify time.

Optional Feature:
- Macro ALIGN_STATS_EN.
- When defined:
  - Adds output err_cnt (16 bits): saturating count of bad headers seen in LOCKED.
  - Adds output lock_loss_cnt (8 bits): saturating count of LOCKED→HUNT transitions.
  - Both counters reset to 0 and are readable at any time.
- When undefined: these ports and counters do not exist. The rest of the behaviour is identical.

Decomposition:
- Shared package phy_130b_pkg holds:
  - BLK_W=130 and SYNC_DATA=2'b01, SYNC_CTRL=2'b10, shared with decoder_128b130b.
  - The align_state_t enum (HUNT, VERIFY, LOCKED).
  - A sync_ok() function.
- One natural sub-module, gearbox_130b: bit buffer, fill count, append/consume(130|131) interface, presenting cand plus fill to the alignment FSM in the parent.

Test Plan:
- Aligned stream, IN_W=32, all headers 01 from bit 0 → no slips; locked and first valid_out after the 4th block; block_out[129:128]=01 and payload matches.
- Stream offset by 57 bits of random prefix → exactly 57 slip_pulse strobes (prefix chosen to yield no false good header), then lock. Payload bit-exact after lock.
- Locked; inject 7 headers of 11 within 64 blocks → locked stays 1. Inject 8 within one window → locked=0 after the 8th block, which is still emitted.
- Locked; 7 bad headers, window wraps, 7 more → no loss of lock (bad_cnt cleared at wrap).
- VERIFY after 3 good headers, then 1 bad → slip_pulse=1, return to HUNT, good_cnt restarts, no valid_out.
- rst_n low mid-block while locked → all outputs 0 immediately. After release, reacquire with the same offset as before. With ALIGN_STATS_EN, err_cnt and lock_loss_cnt read 0.
